ssd_scan_driver: RTL

//   Time-multiplexed N-digit seven-segment display driver: latches a packed hex value,

---
 rtl/ssd_pkg.sv | 28 ++
 rtl/ssd_hex_seg.sv | 19 +
 rtl/ssd_scan_driver.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ssd_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ssd_pkg
// Purpose : Shared constants and helpers for the seven-segment scan driver.
//           SEG_LUT holds active-high {g,f,e,d,c,b,a} hex patterns.
//           apply_pol converts an active-high segment byte to pin polarity.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package ssd_pkg;

  // Index 0 is the rightmost element of the concatenation (hex 0).
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Active-high segment bytes {dp,g,f,e,d,c,b,a}.
  localparam logic [7:0] SEG_OFF    = 8'h00;
  localparam logic [7:0] SEG_ALL_ON = 8'hFF;

  function automatic logic [7:0] apply_pol(input logic [7:0] seg_ah,
                                           input logic       active_low);
    return active_low ? ~seg_ah : seg_ah;
  endfunction

endpackage : ssd_pkg
`default_nettype wire

// File: rtl/ssd_hex_seg.sv
`default_nettype none
// ============================================================================
// Module  : ssd_hex_seg
// Purpose : Combinational hex nibble to active-high 7-segment pattern.
// Ports   : i_nibble [3:0]  hex digit
//           o_seg    [6:0]  {g,f,e,d,c,b,a}, 1 = lit
// Rev     : 1.0  initial release
// ============================================================================
module ssd_hex_seg
  import ssd_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_LUT[i_nibble];

endmodule : ssd_hex_seg
`default_nettype wire

// File: rtl/ssd_scan_driver.sv
`default_nettype none
// ============================================================================
// Module  : ssd_scan_driver
// Purpose : Time-multiplexed N-digit seven-segment driver with ghost
//           blanking, leading-zero suppression, per-digit blank mask,
//           decimal points and configurable pin polarity.
// Ports   : clk, rst              clock, synchronous active-high reset
//           i_load                capture value/dp/mask/lzs this edge
//           i_value [4N-1:0]      packed nibbles, digit 0 = [3:0]
//           i_dp    [N-1:0]       decimal point per digit, 1 = lit
//           i_blank_mask [N-1:0]  1 = digit fully dark
//           i_lzs_en              leading-zero suppression enable
//           o_seg   [7:0]         {dp,g,f,e,d,c,b,a}, pin polarity
//           o_an    [N-1:0]       digit enables, pin polarity
//           o_frame_done          pulse on last cycle of last digit slot
// Rev     : 1.0  initial release
// ============================================================================
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int BLANK_CYCLES   = 16,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [4*N_DIGITS-1:0] i_value,
  input  logic [N_DIGITS-1:0]   i_dp,
  input  logic [N_DIGITS-1:0]   i_blank_mask,
  input  logic                  i_lzs_en,
  output logic [7:0]            o_seg,
  output logic [N_DIGITS-1:0]   o_an,
  output logic                  o_frame_done
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [CNT_W-1:0] c_CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] c_BLANK     = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] c_IDX_LAST  = IDX_W'(N_DIGITS - 1);
  localparam logic             c_SEG_INV   = (SEG_ACTIVE_LOW != 0);
  localparam logic             c_AN_INV    = (AN_ACTIVE_LOW != 0);
  localparam logic [7:0]       c_SEG_IDLE  = c_SEG_INV ? ~SEG_OFF : SEG_OFF;
  localparam logic [N_DIGITS-1:0] c_AN_IDLE = {N_DIGITS{c_AN_INV}};

  // Shadow registers: the pins only ever reflect these, never raw inputs.
  logic [4*N_DIGITS-1:0] r_value;
  logic [N_DIGITS-1:0]   r_dp;
  logic [N_DIGITS-1:0]   r_mask;
  logic                  r_lzs;

  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_value <= '0;
      r_dp    <= '0;
      r_mask  <= '0;
      r_lzs   <= 1'b0;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      if (i_load) begin
        r_value <= i_value;
        r_dp    <= i_dp;
        r_mask  <= i_blank_mask;
        r_lzs   <= i_lzs_en;
      end
      if (r_cnt == c_CNT_LAST) begin
        r_cnt <= '0;
        r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // w_hi_nz[i] = nibble i or any higher nibble is non-zero (prefix-OR from MSB).
  logic [N_DIGITS-1:0] w_hi_nz;
  logic [N_DIGITS-1:0] w_lzs_sup;

  assign w_hi_nz[N_DIGITS-1] = |r_value[4*(N_DIGITS-1) +: 4];

  for (genvar gi = 0; gi < N_DIGITS - 1; gi++) begin : g_prefix
    assign w_hi_nz[gi] = (|r_value[4*gi +: 4]) | w_hi_nz[gi+1];
  end

  // Digit 0 is never suppressed so an all-zero value still shows "0".
  assign w_lzs_sup[0] = 1'b0;
  for (genvar gs = 1; gs < N_DIGITS; gs++) begin : g_lzs
    assign w_lzs_sup[gs] = r_lzs & ~w_hi_nz[gs];
  end

  logic [3:0] w_nibble;
  logic [6:0] w_hex;

  assign w_nibble = r_value[{r_idx, 2'b00} +: 4];

  ssd_hex_seg u_hex_seg (
    .i_nibble (w_nibble),
    .o_seg    (w_hex)
  );

  logic                w_blank;
  logic [7:0]          w_seg_ah;
  logic [N_DIGITS-1:0] w_an_ah;
  logic                w_frame;

  assign w_blank = (r_cnt < c_BLANK);
  assign w_frame = (r_idx == c_IDX_LAST) && (r_cnt == c_CNT_LAST);

  always_comb begin
    w_seg_ah = SEG_OFF;
    w_an_ah  = '0;
    if (!w_blank) begin
      // Masked digits keep their anode on so every slot has equal duty.
      w_an_ah = N_DIGITS'(1) << r_idx;
      if (!r_mask[r_idx]) begin
        w_seg_ah = {r_dp[r_idx], (w_lzs_sup[r_idx] ? 7'h00 : w_hex)};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_seg        <= c_SEG_IDLE;
      o_an         <= c_AN_IDLE;
      o_frame_done <= 1'b0;
    end else begin
      o_seg        <= apply_pol(w_seg_ah, c_SEG_INV);
      o_an         <= w_an_ah ^ c_AN_IDLE;
      o_frame_done <= w_frame;
    end
  end

endmodule : ssd_scan_driver
`default_nettype wire
